// File: rtl/fwb_arbiter.sv
// Writeback arbiter and busy scoreboard for the FPU register-file write port.
// Optional FWB_BYPASS_EN forwards the in-flight write to the three read ports.
module fwb_arbiter #(
  parameter int FLEN = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic [FLEN-1:0] ld_data,
  input  logic            ll_valid,
  output logic            ll_ready,
  input  logic [4:0]      ll_rd,
  input  logic [FLEN-1:0] ll_data,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  input  logic [2:0]      chk_en,
  input  logic [4:0]      chk_a1,
  input  logic [4:0]      chk_a2,
  input  logic [4:0]      chk_a3,
  output logic            stall,
  output logic            we4,
  output logic [4:0]      a4,
  output logic [FLEN-1:0] wd4,
  input  logic [FLEN-1:0] rf_rd1,
  input  logic [FLEN-1:0] rf_rd2,
  input  logic [FLEN-1:0] rf_rd3,
  output logic [FLEN-1:0] fwd_rd1,
  output logic [FLEN-1:0] fwd_rd2,
  output logic [FLEN-1:0] fwd_rd3
);

  logic [4:0]      q_rd   [2];
  logic [FLEN-1:0] q_data [2];
  logic            head;
  logic            tail;
  logic [1:0]      count;
  logic [31:0]     busy;

  logic            push;
  logic            pop;
  logic            sel_valid;
  logic [4:0]      sel_rd;
  logic [FLEN-1:0] sel_data;
  logic [31:0]     set_mask;
  logic [31:0]     clr_mask;

  assign ll_ready = (count != 2'd2);
  assign push     = ll_valid && ll_ready;
  // Loads always take the port; the queue only drains in load-free cycles.
  assign pop      = !ld_valid && (count != 2'd0);

  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = ld_rd;
    sel_data  = ld_data;
    if (ld_valid) begin
      sel_valid = 1'b1;
    end else if (count != 2'd0) begin
      sel_valid = 1'b1;
      sel_rd    = q_rd[head];
      sel_data  = q_data[head];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[tail]   <= ll_rd;
      q_data[tail] <= ll_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) tail <= ~tail;
      if (pop)  head <= ~head;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // A same-cycle issue to the register being retired must leave it busy.
  assign set_mask = iss_valid ? (32'd1 << iss_rd) : 32'd0;
  assign clr_mask = pop ? (32'd1 << q_rd[head]) : 32'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 32'd0;
    end else begin
      busy <= (busy & ~clr_mask) | set_mask;
    end
  end

  assign stall = (chk_en[0] && busy[chk_a1]) ||
                 (chk_en[1] && busy[chk_a2]) ||
                 (chk_en[2] && busy[chk_a3]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we4 <= 1'b0;
      a4  <= 5'd0;
      wd4 <= '0;
    end else begin
      we4 <= sel_valid;
      if (sel_valid) begin
        a4  <= sel_rd;
        wd4 <= sel_data;
      end
    end
  end

  // Covers the half-cycle before the register file commits on negedge.
`ifdef FWB_BYPASS_EN
  assign fwd_rd1 = (we4 && (a4 == chk_a1)) ? wd4 : rf_rd1;
  assign fwd_rd2 = (we4 && (a4 == chk_a2)) ? wd4 : rf_rd2;
  assign fwd_rd3 = (we4 && (a4 == chk_a3)) ? wd4 : rf_rd3;
`else
  assign fwd_rd1 = rf_rd1;
  assign fwd_rd2 = rf_rd2;
  assign fwd_rd3 = rf_rd3;
`endif

endmodule

// File: tb/tb_fwb_arbiter.sv
// Self-checking bench for fwb_arbiter: directed scenarios plus randomized
// traffic compared against a queue-based behavioural model.
module tb_fwb_arbiter;

  localparam int FLEN = 64;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } entry_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            ld_valid;
  logic [4:0]      ld_rd;
  logic [FLEN-1:0] ld_data;
  logic            ll_valid;
  logic            ll_ready;
  logic [4:0]      ll_rd;
  logic [FLEN-1:0] ll_data;
  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic [2:0]      chk_en;
  logic [4:0]      chk_a1, chk_a2, chk_a3;
  logic            stall;
  logic            we4;
  logic [4:0]      a4;
  logic [FLEN-1:0] wd4;
  logic [FLEN-1:0] rf_rd1, rf_rd2, rf_rd3;
  logic [FLEN-1:0] fwd_rd1, fwd_rd2, fwd_rd3;

  int assertCount = 0;
  int failCount   = 0;

  entry_t      mq[$];
  logic [31:0] mbusy;
  logic        e_we4;
  logic [4:0]  e_a4;
  logic [63:0] e_wd4;

  logic [63:0] rfv1, rfv2, rfv3;
  logic        lastStall;
  logic        lastReady;
  logic [63:0] lastFwd2;

  fwb_arbiter #(.FLEN(FLEN)) dut (
    .clk(clk), .reset_n(reset_n),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .chk_en(chk_en), .chk_a1(chk_a1), .chk_a2(chk_a2), .chk_a3(chk_a3),
    .stall(stall), .we4(we4), .a4(a4), .wd4(wd4),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .rf_rd3(rf_rd3),
    .fwd_rd1(fwd_rd1), .fwd_rd2(fwd_rd2), .fwd_rd3(fwd_rd3)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mbusy = 32'd0;
    e_we4 = 1'b0;
    e_a4  = 5'd0;
    e_wd4 = 64'd0;
  endtask

  function automatic logic [63:0] expFwd(input logic [4:0] addr, input logic [63:0] rf);
`ifdef FWB_BYPASS_EN
    return (e_we4 && (e_a4 == addr)) ? e_wd4 : rf;
`else
    return rf;
`endif
  endfunction

  // One clock cycle: check registered outputs, drive inputs, check the
  // combinational outputs, then advance the model across the posedge.
  task automatic applyStimulus(input logic ldv, input logic [4:0] ldrd, input logic [63:0] ldd,
                               input logic llv, input logic [4:0] llrd, input logic [63:0] lld,
                               input logic issv, input logic [4:0] issrd,
                               input logic [2:0] en, input logic [4:0] c1,
                               input logic [4:0] c2, input logic [4:0] c3);
    int     sz;
    entry_t pe;
    logic   expStall;
    @(negedge clk);
    checkOutput("we4", we4, e_we4);
    checkOutput("a4", a4, e_a4);
    checkOutput("wd4", wd4, e_wd4);
    ld_valid = ldv;  ld_rd = ldrd;  ld_data = ldd;
    ll_valid = llv;  ll_rd = llrd;  ll_data = lld;
    iss_valid = issv; iss_rd = issrd;
    chk_en = en; chk_a1 = c1; chk_a2 = c2; chk_a3 = c3;
    rf_rd1 = rfv1; rf_rd2 = rfv2; rf_rd3 = rfv3;
    #1;
    expStall = (en[0] && mbusy[c1]) || (en[1] && mbusy[c2]) || (en[2] && mbusy[c3]);
    checkOutput("ll_ready", ll_ready, mq.size() < 2);
    checkOutput("stall", stall, expStall);
    checkOutput("fwd_rd1", fwd_rd1, expFwd(c1, rfv1));
    checkOutput("fwd_rd2", fwd_rd2, expFwd(c2, rfv2));
    checkOutput("fwd_rd3", fwd_rd3, expFwd(c3, rfv3));
    lastStall = stall;
    lastReady = ll_ready;
    lastFwd2  = fwd_rd2;
    @(posedge clk);
    sz = mq.size();
    if (ldv) begin
      e_we4 = 1'b1; e_a4 = ldrd; e_wd4 = ldd;
    end else if (sz > 0) begin
      pe = mq.pop_front();
      e_we4 = 1'b1; e_a4 = pe.rd; e_wd4 = pe.data;
      mbusy[pe.rd] = 1'b0;
    end else begin
      e_we4 = 1'b0;
    end
    if (llv && sz < 2) mq.push_back({llrd, lld});
    if (issv) mbusy[issrd] = 1'b1;
  endtask

  task automatic idle(input logic [2:0] en, input logic [4:0] c1, input logic [4:0] c2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, en, c1, c2, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    ll_valid = 0; ll_rd = 0; ll_data = 0;
    iss_valid = 0; iss_rd = 0;
    chk_en = 3'b111; chk_a1 = 1; chk_a2 = 2; chk_a3 = 3;
    rfv1 = 64'h11; rfv2 = 64'h22; rfv3 = 64'h33;
    rf_rd1 = rfv1; rf_rd2 = rfv2; rf_rd3 = rfv3;
    modelReset();
    #2;
    checkOutput("rst_we4", we4, 0);
    checkOutput("rst_a4", a4, 0);
    checkOutput("rst_wd4", wd4, 0);
    checkOutput("rst_ready", ll_ready, 1);
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_fwd1", fwd_rd1, 64'h11);
    checkOutput("rst_fwd2", fwd_rd2, 64'h22);
    checkOutput("rst_fwd3", fwd_rd3, 64'h33);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    rfv1 = 0; rfv2 = 0; rfv3 = 0;

    // Load priority over a simultaneous long-latency result
    applyStimulus(1, 5, 64'hAA, 1, 7, 64'h77, 1, 7, 0, 0, 0, 0);
    #1;
    checkOutput("prio_we4", we4, 1);
    checkOutput("prio_a4", a4, 5);
    checkOutput("prio_wd4", wd4, 64'hAA);
    idle(0, 0, 0);
    #1;
    checkOutput("prio_second_a4", a4, 7);
    checkOutput("prio_second_wd4", wd4, 64'h77);
    idle(0, 0, 0);

    // Queue full: three results while loads hold the port
    applyStimulus(1, 1, 64'h101, 1, 10, 64'hA0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 2, 64'h102, 1, 11, 64'hB0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("full_ready_low", ll_ready, 0);
    applyStimulus(1, 3, 64'h103, 1, 12, 64'hC0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 4, 64'h104, 1, 12, 64'hC0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 12, 64'hC0, 0, 0, 0, 0, 0, 0);
    checkOutput("full_ready_pop_cycle", lastReady, 0);
    #1 checkOutput("full_ready_rises", ll_ready, 1);
    applyStimulus(0, 0, 0, 1, 12, 64'hC0, 0, 0, 0, 0, 0, 0);
    checkOutput("full_third_taken", lastReady, 1);
    idle(0, 0, 0);
    #1;
    checkOutput("full_third_a4", a4, 12);
    checkOutput("full_third_wd4", wd4, 64'hC0);
    idle(0, 0, 0);

    // Scoreboard set, clear on pop, and set-wins collision
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0);
    idle(3'b001, 9, 0);
    checkOutput("sb_stall_set", lastStall, 1);
    applyStimulus(0, 0, 0, 1, 9, 64'h99, 0, 0, 3'b001, 9, 0, 0);
    idle(3'b001, 9, 0);
    checkOutput("sb_stall_pop_cycle", lastStall, 1);
    idle(3'b001, 9, 0);
    checkOutput("sb_stall_cleared", lastStall, 0);
    applyStimulus(0, 0, 0, 1, 9, 64'h98, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0);
    idle(3'b001, 9, 0);
    checkOutput("sb_set_wins", lastStall, 1);
    applyStimulus(0, 0, 0, 1, 9, 64'h97, 0, 0, 0, 0, 0, 0);
    idle(0, 0, 0);

    // Forwarding of the in-flight write
    applyStimulus(1, 4, 64'h1234, 0, 0, 0, 0, 0, 0, 0, 4, 0);
    idle(0, 0, 4);
`ifdef FWB_BYPASS_EN
    checkOutput("bypass_fwd2", lastFwd2, 64'h1234);
`else
    checkOutput("bypass_fwd2", lastFwd2, 64'h0);
`endif

    // Reset with two queued results and busy[3] set
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
    applyStimulus(1, 20, 64'h5, 1, 3, 64'h33, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 21, 64'h6, 1, 14, 64'h44, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    ld_valid = 1; ll_valid = 0; iss_valid = 0;
    chk_en = 3'b001; chk_a1 = 3;
    #1;
    checkOutput("mid_stall_before", stall, 1);
    checkOutput("mid_ready_before", ll_ready, 0);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_we4", we4, 0);
    checkOutput("mid_rst_ready", ll_ready, 1);
    checkOutput("mid_rst_stall", stall, 0);
    modelReset();
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rfv1 = {$urandom, $urandom};
      rfv2 = {$urandom, $urandom};
      rfv3 = {$urandom, $urandom};
      applyStimulus(($urandom_range(0, 9) < 4), 5'($urandom), {$urandom, $urandom},
                    ($urandom_range(0, 1) == 1), 5'($urandom), {$urandom, $urandom},
                    ($urandom_range(0, 9) < 3), 5'($urandom),
                    3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
    end
    idle(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
